// File: rtl/thor2022_pkg.sv
// Shared types for the icache invalidation controller.
// THOR2022_ICINV_WALK_EN adds the WALK engine state used for line-by-line invalidate-all.
package thor2022_pkg;

    typedef enum logic [1:0] {
        ICINV_NOP  = 2'b00,
        ICINV_LINE = 2'b01,
        ICINV_ALL  = 2'b10
    } icinv_cmd_t;

    localparam int ICINV_AWID = 32;

    typedef struct packed {
        icinv_cmd_t              cmd;
        logic [ICINV_AWID-1:0]   adr;
    } icinv_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef THOR2022_ICINV_WALK_EN
        ST_ISSUE = 2'd1,
        ST_WALK  = 2'd2
`else
        ST_ISSUE = 2'd1
`endif
    } icinv_state_t;

    function automatic logic cmd_legal(input logic [1:0] cmd);
        return (cmd == ICINV_LINE) || (cmd == ICINV_ALL);
    endfunction

endpackage

// File: rtl/thor2022_icinv_fifo.sv
// DEPTH-entry synchronous FIFO with full/empty/level and async active-low reset.
// Push is ignored while full and pop while empty, regardless of the other side.
module thor2022_icinv_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   level
);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wptr;
    logic [PW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign level = wptr - rptr;
    assign rdata = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/thor2022_icinv_ctrl.sv
// Icache invalidation controller: queues line/all invalidates and issues registered strobes,
// re-issuing on fill collisions. THOR2022_ICINV_WALK_EN turns invalidate-all into a line walk.
module thor2022_icinv_ctrl
    import thor2022_pkg::*;
#(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [1:0]       req_cmd_i,
    input  logic [AWID-1:0]  req_adr_i,
    output logic             req_rdy_o,
    input  logic             fill_wr_i,
    output logic             invce_o,
    output logic             invline_o,
    output logic             invall_o,
    output logic [AWID-1:0]  adr_o,
    output logic             busy_o,
    output logic             done_o,
    output icinv_state_t     dbg_state_o
);

    localparam int LB = $clog2(LINES);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AWID + 2;

    if ((WAYS < 1) || (AWID < 6 + LB) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_cfg_err
        $error("thor2022_icinv_ctrl: unsupported parameter set");
    end

    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [1:0]    head_cmd;
    logic          full;
    logic          empty;
    logic [PW:0]   level;

    icinv_state_t  state_q, state_d;
    logic          invce_q, invce_d;
    logic          invline_q, invline_d;
    logic          invall_q, invall_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          retire;
    logic          load_next;

`ifdef THOR2022_ICINV_WALK_EN
    logic [LB-1:0] walk_q, walk_d;
`endif

    assign req_rdy_o = !full;
    assign push      = req_i && req_rdy_o && cmd_legal(req_cmd_i);
    assign head_cmd  = head[EW-1:AWID];

    thor2022_icinv_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_cmd_i, req_adr_i}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d   = state_q;
        invce_d   = invce_q;
        invline_d = invline_q;
        invall_d  = invall_q;
        adr_d     = adr_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        retire    = 1'b0;
        load_next = 1'b0;
`ifdef THOR2022_ICINV_WALK_EN
        walk_d    = walk_q;
`endif

        case (state_q)
            ST_IDLE:  load_next = !empty;
            ST_ISSUE: retire = !fill_wr_i;
`ifdef THOR2022_ICINV_WALK_EN
            ST_WALK: begin
                if (!fill_wr_i) begin
                    if (walk_q == LB'(LINES - 1)) begin
                        retire = 1'b1;
                    end else begin
                        walk_d            = walk_q + 1'b1;
                        adr_d             = '0;
                        adr_d[6 +: LB]    = walk_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A retiring command hands the strobe straight to the next queued one.
        if (retire) begin
            done_d = 1'b1;
            if (empty) begin
                state_d   = ST_IDLE;
                invce_d   = 1'b0;
                invline_d = 1'b0;
                invall_d  = 1'b0;
                adr_d     = '0;
            end else begin
                load_next = 1'b1;
            end
        end

        if (load_next) begin
            pop     = 1'b1;
            invce_d = 1'b1;
            if (head_cmd == ICINV_LINE) begin
                state_d   = ST_ISSUE;
                invline_d = 1'b1;
                invall_d  = 1'b0;
                adr_d     = head[AWID-1:0];
            end else begin
`ifdef THOR2022_ICINV_WALK_EN
                state_d   = ST_WALK;
                invline_d = 1'b1;
                invall_d  = 1'b0;
                adr_d     = '0;
                walk_d    = '0;
`else
                state_d   = ST_ISSUE;
                invline_d = 1'b0;
                invall_d  = 1'b1;
                adr_d     = '0;
`endif
            end
        end

        busy_d = push || (level != (PW + 1)'(pop)) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            invce_q   <= 1'b0;
            invline_q <= 1'b0;
            invall_q  <= 1'b0;
            adr_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef THOR2022_ICINV_WALK_EN
            walk_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            invce_q   <= invce_d;
            invline_q <= invline_d;
            invall_q  <= invall_d;
            adr_q     <= adr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef THOR2022_ICINV_WALK_EN
            walk_q    <= walk_d;
`endif
        end
    end

    assign invce_o     = invce_q;
    assign invline_o   = invline_q;
    assign invall_o    = invall_q;
    assign adr_o       = adr_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_thor2022_icinv_ctrl.sv
// Directed bench for thor2022_icinv_ctrl; invalidate-all checks follow THOR2022_ICINV_WALK_EN.
module tb_thor2022_icinv_ctrl;
    import thor2022_pkg::*;

    logic          clk;
    logic          rst;
    logic          req_i;
    logic [1:0]    req_cmd_i;
    logic [31:0]   req_adr_i;
    logic          req_rdy_o;
    logic          fill_wr_i;
    logic          invce_o;
    logic          invline_o;
    logic          invall_o;
    logic [31:0]   adr_o;
    logic          busy_o;
    logic          done_o;
    icinv_state_t  dbg_state_o;

    int checks;
    int failures;
    int done_cnt;
    logic [31:0] prev_adr;
    logic [31:0] exp_q[$];

    thor2022_icinv_ctrl #(
        .LINES (128),
        .WAYS  (4),
        .AWID  (32),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .req_cmd_i   (req_cmd_i),
        .req_adr_i   (req_adr_i),
        .req_rdy_o   (req_rdy_o),
        .fill_wr_i   (fill_wr_i),
        .invce_o     (invce_o),
        .invline_o   (invline_o),
        .invall_o    (invall_o),
        .adr_o       (adr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("done_extra", 32'd1, 32'd0);
            else                   chk("done_order", prev_adr, exp_q.pop_front());
        end
        if (invce_o) prev_adr = adr_o;
    endtask

    task automatic single_line(input logic [31:0] a);
        req_i = 1'b1; req_cmd_i = 2'b01; req_adr_i = a;
        step();
        req_i = 1'b0;
        chk("sl_busy_e0", {31'd0, busy_o}, 32'd1);
        chk("sl_invce_e0", {31'd0, invce_o}, 32'd0);
        step();
        chk("sl_invce_e1", {31'd0, invce_o}, 32'd1);
        chk("sl_invline_e1", {31'd0, invline_o}, 32'd1);
        chk("sl_invall_e1", {31'd0, invall_o}, 32'd0);
        chk("sl_adr_e1", adr_o, a);
        chk("sl_done_e1", {31'd0, done_o}, 32'd0);
        step();
        chk("sl_invce_e2", {31'd0, invce_o}, 32'd0);
        chk("sl_done_e2", {31'd0, done_o}, 32'd1);
        chk("sl_busy_e2", {31'd0, busy_o}, 32'd0);
        step();
        chk("sl_done_e3", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0; done_cnt = 0; prev_adr = '0;
        rst = 1'b0; req_i = 1'b0; req_cmd_i = 2'b00; req_adr_i = '0; fill_wr_i = 1'b0;

        // Reset values
        step(); step();
        chk("rst_invce", {31'd0, invce_o}, 32'd0);
        chk("rst_invline", {31'd0, invline_o}, 32'd0);
        chk("rst_invall", {31'd0, invall_o}, 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_rdy", {31'd0, req_rdy_o}, 32'd1);
        rst = 1'b1;
        step();

        // Single invline, no conflict
        single_line(32'h0000_1A40);

        // Same invline with fill collisions in the first two issue cycles
        req_i = 1'b1; req_cmd_i = 2'b01; req_adr_i = 32'h0000_1A40;
        step();
        req_i = 1'b0;
        step();
        chk("col_invce_e1", {31'd0, invce_o}, 32'd1);
        fill_wr_i = 1'b1;
        step();
        chk("col_invce_e2", {31'd0, invce_o}, 32'd1);
        chk("col_done_e2", {31'd0, done_o}, 32'd0);
        step();
        chk("col_invce_e3", {31'd0, invce_o}, 32'd1);
        chk("col_adr_e3", adr_o, 32'h0000_1A40);
        chk("col_done_e3", {31'd0, done_o}, 32'd0);
        fill_wr_i = 1'b0;
        step();
        chk("col_invce_e4", {31'd0, invce_o}, 32'd0);
        chk("col_done_e4", {31'd0, done_o}, 32'd1);
        step();
        chk("col_done_e5", {31'd0, done_o}, 32'd0);

        // Queue fill under a stalled engine: head issued, four queued, one blocked
        fill_wr_i = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_2000 + 32'(i) * 32'd64);
        for (int i = 0; i < 5; i++) begin
            req_i = 1'b1; req_cmd_i = 2'b01; req_adr_i = 32'h0000_2000 + 32'(i) * 32'd64;
            step();
            observe();
            chk("q_rdy", {31'd0, req_rdy_o}, (i < 4) ? 32'd1 : 32'd0);
        end
        req_adr_i = 32'h0000_2140;
        step();
        observe();
        chk("q_rdy_blocked", {31'd0, req_rdy_o}, 32'd0);
        chk("q_head_held", adr_o, 32'h0000_2000);
        chk("q_busy", {31'd0, busy_o}, 32'd1);
        fill_wr_i = 1'b0;
        step();
        observe();
        chk("q_rdy_after_pop", {31'd0, req_rdy_o}, 32'd1);
        step();
        observe();
        req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            observe();
        end
        chk("q_done_count", 32'(done_cnt), 32'd6);
        chk("q_busy_end", {31'd0, busy_o}, 32'd0);

        // Illegal command is dropped
        req_i = 1'b1; req_cmd_i = 2'b11; req_adr_i = 32'h0000_3000;
        step();
        req_i = 1'b0; req_cmd_i = 2'b00;
        chk("ill_busy", {31'd0, busy_o}, 32'd0);
        step();
        chk("ill_invce", {31'd0, invce_o}, 32'd0);
        chk("ill_busy2", {31'd0, busy_o}, 32'd0);
        chk("ill_done", {31'd0, done_o}, 32'd0);

        // Invalidate all
        req_i = 1'b1; req_cmd_i = 2'b10; req_adr_i = 32'hFFFF_FFC0;
        step();
        req_i = 1'b0;
        step();
`ifdef THOR2022_ICINV_WALK_EN
        for (int i = 0; i < 128; i++) begin
            chk("walk_adr", adr_o, 32'(i) << 6);
            chk("walk_line", {30'd0, invline_o, invall_o}, 32'd2);
            chk("walk_invce", {31'd0, invce_o}, 32'd1);
            chk("walk_done", {31'd0, done_o}, 32'd0);
            if (i == 10) begin
                fill_wr_i = 1'b1;
                step();
                chk("walk_stall_adr", adr_o, 32'(i) << 6);
                fill_wr_i = 1'b0;
            end
            step();
        end
        chk("walk_retire_done", {31'd0, done_o}, 32'd1);
        chk("walk_retire_invce", {31'd0, invce_o}, 32'd0);
        step();
        chk("walk_done_once", {31'd0, done_o}, 32'd0);

        // Reset in the middle of a walk
        req_i = 1'b1; req_cmd_i = 2'b10; req_adr_i = '0;
        step();
        req_i = 1'b0;
        step();
        for (int i = 0; i < 50; i++) step();
        chk("rwalk_adr50", adr_o, 32'd50 << 6);
`else
        chk("all_invce", {31'd0, invce_o}, 32'd1);
        chk("all_kind", {30'd0, invline_o, invall_o}, 32'd1);
        chk("all_adr", adr_o, 32'd0);
        step();
        chk("all_invce_off", {31'd0, invce_o}, 32'd0);
        chk("all_done", {31'd0, done_o}, 32'd1);
        step();
        chk("all_done_once", {31'd0, done_o}, 32'd0);

        // Reset while a command is stalled by fills, with another queued
        fill_wr_i = 1'b1;
        req_i = 1'b1; req_cmd_i = 2'b01; req_adr_i = 32'h0000_4000;
        step();
        req_adr_i = 32'h0000_4040;
        step();
        req_i = 1'b0;
        chk("rmid_invce", {31'd0, invce_o}, 32'd1);
`endif
        rst = 1'b0;
        #1;
        chk("rmid_invce_0", {31'd0, invce_o}, 32'd0);
        chk("rmid_invline_0", {31'd0, invline_o}, 32'd0);
        chk("rmid_invall_0", {31'd0, invall_o}, 32'd0);
        chk("rmid_adr_0", adr_o, 32'd0);
        chk("rmid_busy_0", {31'd0, busy_o}, 32'd0);
        chk("rmid_rdy_1", {31'd0, req_rdy_o}, 32'd1);
        fill_wr_i = 1'b0;
        step();
        chk("rmid_done_0", {31'd0, done_o}, 32'd0);
        rst = 1'b1;
        step();
        chk("rpost_done_0", {31'd0, done_o}, 32'd0);
        chk("rpost_invce_0", {31'd0, invce_o}, 32'd0);
        chk("rpost_busy_0", {31'd0, busy_o}, 32'd0);
        single_line(32'h0000_0FC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
